// File: rtl/spu_pkg.sv
// Shared opcodes, formats and stage bookkeeping for the
// SPU even-pipe byte unit.
package spu_pkg;

  localparam int ADDR_W = 7;

  localparam logic [0:10] OP_CNTB  = 11'b01010110100;
  localparam logic [0:10] OP_AVGB  = 11'b00011010011;
  localparam logic [0:10] OP_ABSDB = 11'b00001010011;
  localparam logic [0:10] OP_SUMB  = 11'b01001010011;

  localparam logic [2:0] FMT_RR = 3'd0;

  typedef enum logic [1:0] {
    BOP_CNTB,
    BOP_AVGB,
    BOP_ABSDB,
    BOP_SUMB
  } byte_op_e;

  // Width-independent half of a stage record; the
  // rt field is added where VEC_W is known.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              valid;
  } stage_tag_t;

  function automatic logic [3:0] popcnt8(
    input logic [7:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  function automatic logic [7:0] avg8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  function automatic logic [7:0] absd8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (b >= a) ? (b - a) : (a - b);
  endfunction

  function automatic logic [15:0] sum4(
    input logic [31:0] w
  );
    return {8'h00, w[31:24]} + {8'h00, w[23:16]}
         + {8'h00, w[15:8]}  + {8'h00, w[7:0]};
  endfunction

endpackage

// File: rtl/byte_unit_if.sv
// Issue-side and writeback/forwarding bundle of the
// byte unit; master issues, slave executes.
interface byte_unit_if #(
  parameter int VEC_W   = 128,
  parameter int LATENCY = 4
);

  logic [0:10]      op;
  logic [2:0]       format;
  logic [6:0]       rt_addr;
  logic [0:VEC_W-1] ra;
  logic [0:VEC_W-1] rb;
  logic             reg_write;
  logic             flush;

  logic [0:VEC_W-1] rt_wb;
  logic [6:0]       rt_addr_wb;
  logic             reg_write_wb;

  logic [LATENCY-1:0][0:VEC_W-1] fwd_rt;
  logic [LATENCY-1:0][6:0]       fwd_addr;
  logic [LATENCY-1:0]            fwd_valid;

  modport master (
    output op,
    output format,
    output rt_addr,
    output ra,
    output rb,
    output reg_write,
    output flush,
    input  rt_wb,
    input  rt_addr_wb,
    input  reg_write_wb,
    input  fwd_rt,
    input  fwd_addr,
    input  fwd_valid
  );

  modport slave (
    input  op,
    input  format,
    input  rt_addr,
    input  ra,
    input  rb,
    input  reg_write,
    input  flush,
    output rt_wb,
    output rt_addr_wb,
    output reg_write_wb,
    output fwd_rt,
    output fwd_addr,
    output fwd_valid
  );

endinterface

// File: rtl/byte_alu.sv
// Combinational RR byte-group datapath: cntb, avgb,
// absdb, sumb on big-endian VEC_W operands.
module byte_alu
  import spu_pkg::*;
#(
  parameter int VEC_W = 128
) (
  input  logic [0:10]      op_i,
  input  logic [0:VEC_W-1] ra_i,
  input  logic [0:VEC_W-1] rb_i,
  output logic [0:VEC_W-1] res_o,
  output logic             legal_o
);

  localparam int NB = VEC_W / 8;
  localparam int NW = VEC_W / 32;

  byte_op_e kind;

  always_comb begin
    kind    = BOP_CNTB;
    legal_o = 1'b1;
    unique case (1'b1)
      (op_i == OP_CNTB):  kind = BOP_CNTB;
      (op_i == OP_AVGB):  kind = BOP_AVGB;
      (op_i == OP_ABSDB): kind = BOP_ABSDB;
      (op_i == OP_SUMB):  kind = BOP_SUMB;
      default:            legal_o = 1'b0;
    endcase
  end

  always_comb begin
    res_o = '0;
    unique case (kind)
      BOP_CNTB: begin
        for (int i = 0; i < NB; i++) begin
          res_o[8*i +: 8] =
            {4'h0, popcnt8(ra_i[8*i +: 8])};
        end
      end
      BOP_AVGB: begin
        for (int i = 0; i < NB; i++) begin
          res_o[8*i +: 8] =
            avg8(ra_i[8*i +: 8], rb_i[8*i +: 8]);
        end
      end
      BOP_ABSDB: begin
        for (int i = 0; i < NB; i++) begin
          res_o[8*i +: 8] =
            absd8(ra_i[8*i +: 8], rb_i[8*i +: 8]);
        end
      end
      BOP_SUMB: begin
        // Even halfword carries rb, odd halfword ra.
        for (int w = 0; w < NW; w++) begin
          res_o[32*w +: 16] =
            sum4(rb_i[32*w +: 32]);
          res_o[32*w+16 +: 16] =
            sum4(ra_i[32*w +: 32]);
        end
      end
    endcase
  end

endmodule

// File: rtl/byte_unit.sv
// Byte-op execution pipe: ALU feeding a LATENCY-deep
// staging pipe with flush and per-stage forward taps.
module byte_unit
  import spu_pkg::*;
#(
  parameter int VEC_W   = 128,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  byte_unit_if.slave   bus
);

  typedef struct packed {
    logic [0:VEC_W-1] rt;
    stage_tag_t       tag;
  } stage_t;

  logic [0:VEC_W-1] alu_res;
  logic             alu_legal;

  stage_t                    issue_d;
  stage_t [LATENCY-1:0]      stage_d;
  stage_t [LATENCY-1:0]      stage_q;

  byte_alu #(
    .VEC_W (VEC_W)
  ) u_alu (
    .op_i    (bus.op),
    .ra_i    (bus.ra),
    .rb_i    (bus.rb),
    .res_o   (alu_res),
    .legal_o (alu_legal)
  );

  // Nops, foreign formats and unknown ops all
  // enter as an all-zero bubble.
  always_comb begin
    issue_d = '0;
    if (bus.format == FMT_RR && alu_legal) begin
      issue_d.rt        = alu_res;
      issue_d.tag.addr  = bus.rt_addr;
      issue_d.tag.valid = bus.reg_write;
    end
  end

  always_comb begin
    stage_d[0] = issue_d;
    for (int k = 1; k < LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    // Flush only kills the write; data keeps moving.
    if (bus.flush) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_d[k].tag.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.rt_wb        = stage_q[LATENCY-1].rt;
  assign bus.rt_addr_wb   = stage_q[LATENCY-1].tag.addr;
  assign bus.reg_write_wb = stage_q[LATENCY-1].tag.valid;

  for (genvar k = 0; k < LATENCY; k++) begin : g_fwd
    assign bus.fwd_rt[k]    = stage_q[k].rt;
    assign bus.fwd_addr[k]  = stage_q[k].tag.addr;
    assign bus.fwd_valid[k] = stage_q[k].tag.valid;
  end

endmodule

// File: tb/tb_byte_unit.sv
// Directed bench for byte_unit: scoreboard on the
// default pipe plus latency checks on two variants.
module tb_byte_unit;

  localparam int L = 4;

  localparam logic [10:0] C_CNTB  = 11'b01010110100;
  localparam logic [10:0] C_AVGB  = 11'b00011010011;
  localparam logic [10:0] C_ABSDB = 11'b00001010011;
  localparam logic [10:0] C_SUMB  = 11'b01001010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  byte_unit_if #(.VEC_W(128), .LATENCY(4)) b4 ();
  byte_unit_if #(.VEC_W(32),  .LATENCY(2)) b2 ();
  byte_unit_if #(.VEC_W(256), .LATENCY(8)) b8 ();

  byte_unit #(.VEC_W(128), .LATENCY(4)) u4 (
    .clk(clk), .reset(rst_n), .bus(b4));
  byte_unit #(.VEC_W(32), .LATENCY(2)) u2 (
    .clk(clk), .reset(rst_n), .bus(b2));
  byte_unit #(.VEC_W(256), .LATENCY(8)) u8 (
    .clk(clk), .reset(rst_n), .bus(b8));

  typedef struct {
    logic [127:0] rt;
    logic [6:0]   addr;
    logic         valid;
    int           due;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  task automatic cmp(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] want);
    vecs++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, want);
    end
  endtask

  function automatic logic [127:0] model(
    input logic [10:0] op, input logic [2:0] fmt,
    input logic [127:0] ra, input logic [127:0] rb,
    output bit ok);
    logic [127:0] r;
    int a, b, sa, sbv;
    r = '0;
    ok = 1'b1;
    if (fmt != 3'd0) ok = 1'b0;
    else if (op == C_CNTB)
      for (int i = 0; i < 16; i++)
        r[127-8*i -: 8] = 8'($countones(ra[127-8*i -: 8]));
    else if (op == C_AVGB || op == C_ABSDB)
      for (int i = 0; i < 16; i++) begin
        a = int'(ra[127-8*i -: 8]);
        b = int'(rb[127-8*i -: 8]);
        if (op == C_AVGB) r[127-8*i -: 8] = 8'((a + b + 1) / 2);
        else r[127-8*i -: 8] = 8'(a > b ? a - b : b - a);
      end
    else if (op == C_SUMB)
      for (int w = 0; w < 4; w++) begin
        sa = 0;
        sbv = 0;
        for (int j = 0; j < 4; j++) begin
          sa  += int'(ra[127-32*w-8*j -: 8]);
          sbv += int'(rb[127-32*w-8*j -: 8]);
        end
        r[127-32*w -: 16] = 16'(sbv);
        r[111-32*w -: 16] = 16'(sa);
      end
    else ok = 1'b0;
    return r;
  endfunction

  task automatic idle_all();
    b4.op = '0; b4.format = '0; b4.rt_addr = '0;
    b4.ra = '0; b4.rb = '0;
    b4.reg_write = 1'b0; b4.flush = 1'b0;
    b2.op = '0; b2.format = '0; b2.rt_addr = '0;
    b2.ra = '0; b2.rb = '0;
    b2.reg_write = 1'b0; b2.flush = 1'b0;
    b8.op = '0; b8.format = '0; b8.rt_addr = '0;
    b8.ra = '0; b8.rb = '0;
    b8.reg_write = 1'b0; b8.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.tag, ".due"}, 256'(cyc), 256'(e.due));
      cmp({e.tag, ".rt"}, 256'(b4.rt_wb), 256'(e.rt));
      cmp({e.tag, ".addr"}, 256'(b4.rt_addr_wb),
          256'(e.addr));
      cmp({e.tag, ".wr"}, 256'(b4.reg_write_wb),
          256'(e.valid));
    end
  endtask

  task automatic drive(input string tag,
                       input logic [10:0] op,
                       input logic [2:0] fmt,
                       input logic [6:0] addr,
                       input logic [127:0] ra,
                       input logic [127:0] rb,
                       input logic rw,
                       input logic fl);
    exp_t e;
    bit ok;
    logic [127:0] r;
    b4.op = op; b4.format = fmt; b4.rt_addr = addr;
    b4.ra = ra; b4.rb = rb;
    b4.reg_write = rw; b4.flush = fl;
    r = model(op, fmt, ra, rb, ok);
    if (fl) foreach (sb[i]) sb[i].valid = 1'b0;
    e.rt    = ok ? r : '0;
    e.addr  = ok ? addr : 7'd0;
    e.valid = ok && rw && !fl;
    e.due   = cyc + L;
    e.tag   = tag;
    sb.push_back(e);
    tick();
    idle_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  logic [127:0] ones, c01, r1, r2;

  initial begin
    ones = '1;
    c01  = {16{8'h01}};
    idle_all();
    idle(2);
    cmp("rst.wb", 256'(b4.rt_wb), 256'(0));
    cmp("rst.wr", 256'(b4.reg_write_wb), 256'(0));
    cmp("rst.fwdv", 256'(b4.fwd_valid), 256'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      drive("pre", C_CNTB, 3'd0, 7'(i + 1),
            {4{$urandom}}, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    cmp("arst.wb", 256'(b4.rt_wb), 256'(0));
    cmp("arst.addr", 256'(b4.rt_addr_wb), 256'(0));
    cmp("arst.wr", 256'(b4.reg_write_wb), 256'(0));
    cmp("arst.fwdv", 256'(b4.fwd_valid), 256'(0));
    cmp("arst.fwdrt", 256'(|b4.fwd_rt), 256'(0));
    sb.delete();
    idle(1);
    rst_n = 1'b1;

    drive("cntb", C_CNTB, 3'd0, 7'd5, ones, '0,
          1'b1, 1'b0);
    idle(2);
    cmp("lat.early", 256'(b4.reg_write_wb), 256'(0));
    idle(1);
    cmp("cntb.const", 256'(b4.rt_wb),
        256'({16{8'h08}}));

    drive("avg1", C_AVGB, 3'd0, 7'd10, ones, c01,
          1'b1, 1'b0);
    drive("absd1", C_ABSDB, 3'd0, 7'd11, ones, c01,
          1'b1, 1'b0);
    drive("avg2", C_AVGB, 3'd0, 7'd12, c01, ones,
          1'b1, 1'b0);
    drive("absd2", C_ABSDB, 3'd0, 7'd13, c01, ones,
          1'b1, 1'b0);
    idle(1);
    cmp("absd.const", 256'(b4.rt_wb),
        256'({16{8'hFE}}));
    idle(3);

    drive("sumb", C_SUMB, 3'd0, 7'd20, ones,
          {4{32'h01020304}}, 1'b1, 1'b0);
    cmp("fwd0.rt", 256'(b4.fwd_rt[0]),
        256'({4{32'h000A03FC}}));
    cmp("fwd0.addr", 256'(b4.fwd_addr[0]), 256'(20));
    cmp("fwd0.v", 256'(b4.fwd_valid[0]), 256'(1));
    idle(1);
    cmp("fwd1.addr", 256'(b4.fwd_addr[1]), 256'(20));
    idle(3);

    drive("nop", 11'h000, 3'd0, 7'd9, ones, ones,
          1'b1, 1'b0);
    drive("fmt1", C_CNTB, 3'd1, 7'd9, ones, ones,
          1'b1, 1'b0);
    drive("ill", 11'h7FF, 3'd0, 7'd9, ones, ones,
          1'b1, 1'b0);
    drive("same1", C_CNTB, 3'd0, 7'd3, {4{32'h0F0F0F0F}},
          '0, 1'b1, 1'b0);
    drive("same2", C_AVGB, 3'd0, 7'd3, ones, '0,
          1'b1, 1'b0);
    idle(4);

    for (int i = 0; i < 6; i++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom, $urandom};
      case (i % 4)
        0: drive("rnd", C_CNTB, 3'd0, 7'(i), r1, r2, 1'b1, 1'b0);
        1: drive("rnd", C_AVGB, 3'd0, 7'(i), r1, r2, 1'b1, 1'b0);
        2: drive("rnd", C_ABSDB, 3'd0, 7'(i), r1, r2, 1'b0, 1'b0);
        default: drive("rnd", C_SUMB, 3'd0, 7'(i), r1, r2, 1'b1, 1'b0);
      endcase
    end
    idle(4);

    for (int i = 0; i < 4; i++)
      drive("fl.op", C_CNTB, 3'd0, 7'(40 + i),
            {4{$urandom}}, '0, 1'b1, 1'b0);
    drive("fl.kill", C_ABSDB, 3'd0, 7'd44, ones, c01,
          1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(1);
      cmp("fl.fwdv", 256'(b4.fwd_valid), 256'(0));
      cmp("fl.wr", 256'(b4.reg_write_wb), 256'(0));
    end
    drive("fl.after", C_AVGB, 3'd0, 7'd45, ones, c01,
          1'b1, 1'b0);
    idle(4);

    b2.op = C_CNTB; b2.rt_addr = 7'd5;
    b2.ra = '1; b2.reg_write = 1'b1;
    b8.op = C_CNTB; b8.rt_addr = 7'd5;
    b8.ra = '1; b8.reg_write = 1'b1;
    tick();
    idle_all();
    for (int k = 0; k < 9; k++) begin
      cmp("l2.wr", 256'(b2.reg_write_wb), 256'(k == 1));
      cmp("l2.rt", 256'(b2.rt_wb),
          256'(k == 1 ? 32'h08080808 : 32'h0));
      cmp("l8.wr", 256'(b8.reg_write_wb), 256'(k == 7));
      cmp("l8.rt", 256'(b8.rt_wb),
          k == 7 ? {32{8'h08}} : 256'(0));
      cmp("l8.addr", 256'(b8.rt_addr_wb),
          256'(k == 7 ? 5 : 0));
      tick();
    end

    cmp("sb.empty", 256'(sb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
